// File: rtl/warp_pc_unit.sv
// Per-warp program counters with return-address stacks; resolves seq/branch/jump/call/ret/halt.
// Updates land one cycle after acceptance; reads are combinational; no backpressure, ignored updates are dropped.
module warp_pc_unit #(
    parameter int PC_ADDR_WIDTH = 8,
    parameter int NUM_WARPS     = 4,
    parameter int INSTR_BYTES   = 2,
    parameter int STACK_DEPTH   = 4,
    parameter int WARP_W        = $clog2(NUM_WARPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PC_ADDR_WIDTH-1:0] start_pc,
    input  logic                     upd_valid,
    input  logic [WARP_W-1:0]        upd_warp,
    input  logic [3:0]               upd_opcode,
    input  logic                     cmp_lt,
    input  logic                     cmp_eq,
    input  logic [PC_ADDR_WIDTH-1:0] br_target,
    input  logic [WARP_W-1:0]        rd_warp,
    output logic [PC_ADDR_WIDTH-1:0] rd_pc,
    output logic                     rd_running,
    output logic                     upd_taken,
    output logic [NUM_WARPS-1:0]     warp_halted,
    output logic [NUM_WARPS-1:0]     stack_err,
    output logic                     all_done
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0]          DEPTH_SP = SP_W'(STACK_DEPTH);
    localparam logic [PC_ADDR_WIDTH-1:0] INC      = PC_ADDR_WIDTH'(INSTR_BYTES);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} warp_state_t;

    warp_state_t              state_q [NUM_WARPS];
    logic [PC_ADDR_WIDTH-1:0] pc_q    [NUM_WARPS];
    logic [SP_W-1:0]          sp_q    [NUM_WARPS];
    logic [PC_ADDR_WIDTH-1:0] stack_q [NUM_WARPS][STACK_DEPTH];

    logic [PC_ADDR_WIDTH-1:0] cur_pc, seq, nxt_pc;
    logic [SP_W-1:0]          cur_sp, nxt_sp;
    logic [IDX_W-1:0]         top_idx, push_idx;
    logic                     accept, push, halt, err, taken;

    assign accept = upd_valid && !start && (state_q[upd_warp] == RUN);

    always_comb begin
        cur_pc   = pc_q[upd_warp];
        cur_sp   = sp_q[upd_warp];
        seq      = cur_pc + INC;
        top_idx  = IDX_W'(cur_sp - SP_W'(1));
        push_idx = IDX_W'(cur_sp);
        nxt_pc   = seq;
        nxt_sp   = cur_sp;
        push     = 1'b0;
        halt     = 1'b0;
        err      = 1'b0;
        taken    = 1'b0;
        case (upd_opcode)
            4'd4:  taken = !cmp_eq;
            4'd5:  taken = cmp_eq;
            4'd6:  taken = cmp_lt && !cmp_eq;
            4'd7:  taken = !cmp_lt && !cmp_eq;
            4'd8:  taken = 1'b1;
            4'd9: begin
                if (cur_sp < DEPTH_SP) begin
                    push   = 1'b1;
                    nxt_sp = cur_sp + SP_W'(1);
                    taken  = 1'b1;
                end else begin
                    err  = 1'b1;
                    halt = 1'b1;
                end
            end
            4'd10: begin
                if (cur_sp != '0) begin
                    nxt_sp = cur_sp - SP_W'(1);
                    taken  = 1'b1;
                end else begin
                    err  = 1'b1;
                    halt = 1'b1;
                end
            end
            4'd15: halt = 1'b1;
            default: ;
        endcase
        // Taken branch/jump/call go to br_target; a taken RET goes to the popped entry.
        if (halt)
            nxt_pc = cur_pc;
        else if (taken)
            nxt_pc = (upd_opcode == 4'd10) ? stack_q[upd_warp][top_idx] : br_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= IDLE;
                pc_q[w]    <= '0;
                sp_q[w]    <= '0;
            end
            stack_err <= '0;
            upd_taken <= 1'b0;
        end else if (start) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= RUN;
                pc_q[w]    <= start_pc;
                sp_q[w]    <= '0;
            end
            stack_err <= '0;
            upd_taken <= 1'b0;
        end else begin
            upd_taken <= accept && taken;
            if (accept) begin
                pc_q[upd_warp] <= nxt_pc;
                sp_q[upd_warp] <= nxt_sp;
                if (push)
                    stack_q[upd_warp][push_idx] <= seq;
                if (halt)
                    state_q[upd_warp] <= HALTED;
                if (err)
                    stack_err[upd_warp] <= 1'b1;
            end
        end
    end

    always_comb begin
        warp_halted = '0;
        for (int w = 0; w < NUM_WARPS; w++)
            warp_halted[w] = (state_q[w] == HALTED);
    end

    assign all_done   = &warp_halted;
    assign rd_pc      = pc_q[rd_warp];
    assign rd_running = (state_q[rd_warp] == RUN);

endmodule

// File: tb/tb_warp_pc_unit.sv
// Directed bench for warp_pc_unit: vector table for branch resolution plus hand sequences for stack/halt/start/reset.
module tb_warp_pc_unit;

    logic       clk = 1'b0;
    logic       reset, start, upd_valid, cmp_lt, cmp_eq;
    logic [7:0] start_pc, br_target, rd_pc;
    logic [1:0] upd_warp, rd_warp;
    logic [3:0] upd_opcode;
    logic       rd_running, upd_taken, all_done;
    logic [3:0] warp_halted, stack_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    warp_pc_unit dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .upd_valid(upd_valid), .upd_warp(upd_warp), .upd_opcode(upd_opcode),
        .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .br_target(br_target),
        .rd_warp(rd_warp), .rd_pc(rd_pc), .rd_running(rd_running),
        .upd_taken(upd_taken), .warp_halted(warp_halted),
        .stack_err(stack_err), .all_done(all_done)
    );

    typedef struct {
        logic [1:0] warp;
        logic [3:0] op;
        logic       lt;
        logic       eq;
        logic [7:0] tgt;
        logic [7:0] exp_pc;
        logic       exp_taken;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [1:0] w, input logic [3:0] op, input logic lt,
                          input logic eq, input logic [7:0] tgt);
        upd_valid  = 1'b1;
        upd_warp   = w;
        upd_opcode = op;
        cmp_lt     = lt;
        cmp_eq     = eq;
        br_target  = tgt;
        step();
        upd_valid  = 1'b0;
    endtask

    task automatic pc_of(input logic [1:0] w, output logic [7:0] pc, output logic run);
        rd_warp = w;
        #1;
        pc  = rd_pc;
        run = rd_running;
    endtask

    logic [7:0] pc;
    logic       run;

    initial begin
        vecs[0]  = '{2'd2, 4'd8, 1'b0, 1'b0, 8'h20, 8'h20, 1'b1};
        vecs[1]  = '{2'd2, 4'd5, 1'b0, 1'b1, 8'h40, 8'h40, 1'b1};
        vecs[2]  = '{2'd2, 4'd6, 1'b1, 1'b1, 8'h40, 8'h42, 1'b0};
        vecs[3]  = '{2'd2, 4'd7, 1'b0, 1'b0, 8'h40, 8'h40, 1'b1};
        vecs[4]  = '{2'd2, 4'd4, 1'b0, 1'b1, 8'h40, 8'h42, 1'b0};
        vecs[5]  = '{2'd2, 4'd4, 1'b0, 1'b0, 8'h60, 8'h60, 1'b1};
        vecs[6]  = '{2'd2, 4'd6, 1'b1, 1'b0, 8'h70, 8'h70, 1'b1};
        vecs[7]  = '{2'd2, 4'd5, 1'b0, 1'b0, 8'h90, 8'h72, 1'b0};
        vecs[8]  = '{2'd2, 4'd8, 1'b0, 1'b0, 8'hFE, 8'hFE, 1'b1};
        vecs[9]  = '{2'd2, 4'd0, 1'b0, 1'b0, 8'h33, 8'h00, 1'b0};
        vecs[10] = '{2'd2, 4'd3, 1'b0, 1'b0, 8'h33, 8'h02, 1'b0};
        vecs[11] = '{2'd2, 4'd7, 1'b1, 1'b0, 8'h33, 8'h04, 1'b0};

        reset = 1'b1; start = 1'b0; start_pc = 8'h00; upd_valid = 1'b0;
        upd_warp = 2'd0; upd_opcode = 4'd0; cmp_lt = 1'b0; cmp_eq = 1'b0;
        br_target = 8'h00; rd_warp = 2'd0;
        step(); step();
        reset = 1'b0;
        chk("reset_pc", rd_pc, 8'h00);
        chk("reset_running", rd_running, 1'b0);
        chk("reset_taken", upd_taken, 1'b0);
        chk("reset_halted", warp_halted, 4'b0000);
        chk("reset_stack_err", stack_err, 4'b0000);
        chk("reset_all_done", all_done, 1'b0);

        // An update before start must be dropped: warps are IDLE.
        do_upd(2'd0, 4'd8, 1'b0, 1'b0, 8'h55);
        chk("idle_upd_taken", upd_taken, 1'b0);
        chk("idle_upd_pc", rd_pc, 8'h00);

        start = 1'b1; start_pc = 8'h10;
        step();
        start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            pc_of(2'(w), pc, run);
            chk($sformatf("start_pc_w%0d", w), pc, 8'h10);
            chk($sformatf("start_run_w%0d", w), run, 1'b1);
        end
        chk("start_all_done", all_done, 1'b0);

        do_upd(2'd1, 4'd0, 1'b0, 1'b0, 8'h00);
        pc_of(2'd1, pc, run);
        chk("seq_w1_pc", pc, 8'h12);
        pc_of(2'd0, pc, run);
        chk("seq_w0_hold", pc, 8'h10);
        chk("seq_taken", upd_taken, 1'b0);

        for (int i = 0; i < 12; i++) begin
            do_upd(vecs[i].warp, vecs[i].op, vecs[i].lt, vecs[i].eq, vecs[i].tgt);
            pc_of(vecs[i].warp, pc, run);
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_taken", i), upd_taken, vecs[i].exp_taken);
        end
        pc_of(2'd1, pc, run);
        chk("vec_w1_isolated", pc, 8'h12);

        // Idle cycle clears upd_taken.
        do_upd(2'd0, 4'd8, 1'b0, 1'b0, 8'h80);
        upd_valid = 1'b0;
        step();
        chk("idle_cycle_taken", upd_taken, 1'b0);
        start = 1'b1; start_pc = 8'h10;
        step();
        start = 1'b0;

        do_upd(2'd0, 4'd9, 1'b0, 1'b0, 8'h80);
        pc_of(2'd0, pc, run);
        chk("call_pc", pc, 8'h80);
        chk("call_taken", upd_taken, 1'b1);
        do_upd(2'd0, 4'd10, 1'b0, 1'b0, 8'h00);
        pc_of(2'd0, pc, run);
        chk("ret_pc", pc, 8'h12);
        chk("ret_taken", upd_taken, 1'b1);

        for (int i = 0; i < 4; i++)
            do_upd(2'd0, 4'd9, 1'b0, 1'b0, 8'(8'h80 + 8'h10 * i));
        pc_of(2'd0, pc, run);
        chk("call4_pc", pc, 8'hB0);
        chk("call4_no_err", stack_err, 4'b0000);
        do_upd(2'd0, 4'd9, 1'b0, 1'b0, 8'hC0);
        pc_of(2'd0, pc, run);
        chk("ovf_pc", pc, 8'hB0);
        chk("ovf_taken", upd_taken, 1'b0);
        chk("ovf_err", stack_err, 4'b0001);
        chk("ovf_halted", warp_halted, 4'b0001);
        chk("ovf_running", run, 1'b0);

        do_upd(2'd3, 4'd10, 1'b0, 1'b0, 8'h00);
        pc_of(2'd3, pc, run);
        chk("udf_pc", pc, 8'h10);
        chk("udf_err", stack_err, 4'b1001);
        chk("udf_halted", warp_halted, 4'b1001);

        do_upd(2'd1, 4'd15, 1'b0, 1'b0, 8'h00);
        chk("halt_w1", warp_halted, 4'b1011);
        chk("halt_w1_done", all_done, 1'b0);
        chk("halt_w1_taken", upd_taken, 1'b0);
        do_upd(2'd2, 4'd15, 1'b0, 1'b0, 8'h00);
        chk("halt_w2", warp_halted, 4'b1111);
        chk("halt_all_done", all_done, 1'b1);
        do_upd(2'd2, 4'd8, 1'b0, 1'b0, 8'h77);
        pc_of(2'd2, pc, run);
        chk("halted_upd_pc", pc, 8'h10);
        chk("halted_upd_taken", upd_taken, 1'b0);

        start = 1'b1; start_pc = 8'h30;
        step();
        start = 1'b0;
        chk("restart_halted", warp_halted, 4'b0000);
        chk("restart_err", stack_err, 4'b0000);
        chk("restart_done", all_done, 1'b0);
        pc_of(2'd3, pc, run);
        chk("restart_w3_pc", pc, 8'h30);
        chk("restart_w3_run", run, 1'b1);

        // start wins over a same-cycle update.
        start = 1'b1; start_pc = 8'h50;
        do_upd(2'd0, 4'd8, 1'b0, 1'b0, 8'h99);
        start = 1'b0;
        pc_of(2'd0, pc, run);
        chk("start_wins_pc", pc, 8'h50);
        chk("start_wins_taken", upd_taken, 1'b0);

        // Nested calls return in LIFO order.
        do_upd(2'd1, 4'd9, 1'b0, 1'b0, 8'h80);
        do_upd(2'd1, 4'd9, 1'b0, 1'b0, 8'hA0);
        do_upd(2'd1, 4'd10, 1'b0, 1'b0, 8'h00);
        pc_of(2'd1, pc, run);
        chk("lifo_ret1", pc, 8'h82);
        do_upd(2'd1, 4'd10, 1'b0, 1'b0, 8'h00);
        pc_of(2'd1, pc, run);
        chk("lifo_ret2", pc, 8'h52);

        do_upd(2'd0, 4'd8, 1'b0, 1'b0, 8'h66);
        chk("pre_reset_taken", upd_taken, 1'b1);
        reset = 1'b1;
        do_upd(2'd0, 4'd9, 1'b0, 1'b0, 8'hE0);
        reset = 1'b0;
        pc_of(2'd0, pc, run);
        chk("mid_reset_pc", pc, 8'h00);
        chk("mid_reset_run", run, 1'b0);
        chk("mid_reset_taken", upd_taken, 1'b0);
        chk("mid_reset_halted", warp_halted, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/warp_pc_unit.md
Name: warp_pc_unit

Overview:
- Multi-warp successor to the single-thread PC counter.
- Holds one PC, one run state and one return-address stack per warp, and resolves sequential, conditional-branch, jump, call, return and halt updates.
- Sits between the control unit/scheduler (which issues resolved instruction updates) and instruction fetch (which reads the PC of the selected warp).

Parameters:
- PC_ADDR_WIDTH, 8, PC width in bits.
- NUM_WARPS, 4, number of independent warps (power of two, at least 2).
- INSTR_BYTES, 2, sequential PC increment.
- STACK_DEPTH, 4, return-address entries per warp (at least 1).
- WARP_W, $clog2(NUM_WARPS), warp index width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse: initialise all warps.
- start_pc  in  PC_ADDR_WIDTH  initial PC for every warp.
- upd_valid  in  1  update request this cycle.
- upd_warp  in  WARP_W  warp being updated.
- upd_opcode  in  4  opcode of the executed instruction.
- cmp_lt  in  1  compare result, less-than.
- cmp_eq  in  1  compare result, equal.
- br_target  in  PC_ADDR_WIDTH  branch/jump/call destination.
- rd_warp  in  WARP_W  fetch read select.
- rd_pc  out  PC_ADDR_WIDTH  current PC of rd_warp (combinational read).
- rd_running  out  1  rd_warp is in RUN.
- upd_taken  out  1  registered: previous accepted update redirected control flow.
- warp_halted  out  NUM_WARPS  per-warp HALTED flag.
- stack_err  out  NUM_WARPS  sticky per-warp overflow/underflow flag.
- all_done  out  1  every warp is HALTED.

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high. reset has priority over all other inputs.
- Reset values: all PCs 0, all warps IDLE, stack pointers 0, upd_taken 0, stack_err 0, warp_halted 0, all_done 0.
- Per-warp state machine (IDLE, RUN, HALTED):
  - IDLE -> RUN on start.
  - RUN -> HALTED on HALT or a stack error.
  - HALTED -> RUN only on start.
- start:
  - Every warp's PC <= start_pc, SP <= 0, stack_err cleared, state <= RUN.
  - Any upd_valid in the same cycle is ignored.
- Update acceptance: accepted only when upd_valid=1, start=0 and upd_warp is in RUN. Otherwise ignored, with no state change and upd_taken <= 0.
- Update result: next PC is registered one cycle after acceptance. seq = PC + INSTR_BYTES, modulo 2^PC_ADDR_WIDTH (wraps silently). Opcode decode:
  - 4 BNE: taken if !cmp_eq.
  - 5 BEQ: taken if cmp_eq.
  - 6 BLT: taken if cmp_lt && !cmp_eq.
  - 7 BGT: taken if !cmp_lt && !cmp_eq.
  - 8 JMP: always taken, PC <= br_target.
  - 9 CALL:
    - If SP < STACK_DEPTH: push seq, SP+1, PC <= br_target, taken.
    - Else: overflow. stack_err set, state HALTED, PC and stack unchanged, upd_taken 0.
  - 10 RET:
    - If SP > 0: PC <= top entry, SP-1, taken.
    - Else: underflow. stack_err set, HALTED, PC unchanged.
  - 15 HALT: PC unchanged, state HALTED, upd_taken 0.
  - Any other opcode: PC <= seq, upd_taken 0.
  - Conditional branches: taken => PC <= br_target, upd_taken 1; not taken => PC <= seq.
- upd_taken: updated every cycle (1 only for a taken accepted update, else 0).
- Warp isolation: only one warp updates per cycle. Other warps' PCs, stacks and states hold.
- Read port: rd_pc and rd_running reflect register state combinationally, so an update is visible on the cycle after acceptance.
- Status outputs: warp_halted and all_done are derived from state registers. all_done is 0 while any warp is IDLE or RUN.
- Reset mid-operation returns every warp to IDLE immediately, regardless of pending update or stack contents.

Test Plan:
- Reset, start with start_pc=0x10 -> all rd_pc=0x10, rd_running=1, all_done=0. Then upd warp1 opcode 0 -> warp1 PC 0x12 next cycle; warp0 stays 0x10.
- Branches on warp2 at PC 0x20, br_target=0x40:
  - BEQ cmp_eq=1 -> PC 0x40, upd_taken=1.
  - BLT cmp_lt=1, cmp_eq=1 -> 0x42, upd_taken=0.
  - BGT lt=0, eq=0 -> taken.
  - BNE eq=1 -> not taken.
- PC_ADDR_WIDTH=8, PC=0xFE, opcode 0 -> PC 0x00 (wrap).
- Call/return, STACK_DEPTH=4, warp0 at 0x10:
  - CALL 0x80 -> PC 0x80.
  - RET -> 0x12.
  - Five nested CALLs -> fifth sets stack_err[0], warp0 HALTED, PC unchanged.
  - RET on empty stack in warp3 -> stack_err[3], HALTED.
- HALT each warp in turn -> warp_halted bits set progressively; all_done=1 after the last. Update to a halted warp -> ignored. start -> all RUN, stack_err cleared.
- upd_valid with start in the same cycle -> start wins. reset asserted mid-CALL -> PCs 0, IDLE, upd_taken 0.
